vlog_rr_arbiter: RTL and testbench

//  N-way round-robin arbiter with grant-hold. Shares one downstream resource (bus/port) between N requesters.

---
 rtl/vlog_arb_pkg.sv | 22 ++
 rtl/vlog_rr_pick.sv | 35 +++
 rtl/vlog_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_vlog_rr_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vlog_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package vlog_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_MAX_N = 16;

  // Input must be one-hot or zero; a zero vector maps to index 0.
  function automatic logic [3:0] onehot2idx(input logic [ARB_MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vlog_rr_pick.sv
// Combinational rotating priority encoder: first set request at or above ptr_i, with wrap.
module vlog_rr_pick
  import vlog_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           any_o,
  output logic [IDW-1:0] winnerId_o,
  output logic [N-1:0]   winnerOh_o
);

  logic [N-1:0] rotReq;
  logic [N-1:0] rotOh;
  logic         found;

  // Rotate so ptr_i sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rotReq     = N'({req_i, req_i} >> ptr_i);
    rotOh      = '0;
    found      = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && rotReq[j]) begin
        rotOh[j] = 1'b1;
        found    = 1'b1;
      end
    end
    winnerOh_o = N'(({rotOh, rotOh} << ptr_i) >> N);
    any_o      = found;
    winnerId_o = IDW'(onehot2idx(ARB_MAX_N'(winnerOh_o)));
  end

endmodule

// File: rtl/vlog_rr_arbiter.sv
// N-way round-robin arbiter with grant-hold and a mandatory release cycle.
// Optional forced revoke of long grants: define VLOG_RR_ARB_TIMEOUT_EN.
module vlog_rr_arbiter
  import vlog_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld,
  output logic           timeout
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gntId_q, gntId_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gntVld_q, gntVld_d;

  logic           winAny;
  logic [IDW-1:0] winId;
  logic [N-1:0]   winOh;
  logic           holderReq;
  logic           holdExpired;

  vlog_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .any_o      (winAny),
    .winnerId_o (winId),
    .winnerOh_o (winOh)
  );

  assign holderReq = |(req & gnt_q);

`ifdef VLOG_RR_ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD);

  logic [HCW-1:0] holdCnt_q, holdCnt_d;
  logic           timeout_q, timeout_d;

  assign holdExpired = (holdCnt_q == HCW'(MAX_HOLD - 1));

  // Counter sits at zero outside GRANT, so every new grant starts from zero.
  always_comb begin
    holdCnt_d = '0;
    timeout_d = 1'b0;
    if (state_q == ARB_GRANT) begin
      holdCnt_d = holdCnt_q + HCW'(1);
      timeout_d = holderReq && holdExpired;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign holdExpired = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gntId_d  = gntId_q;
    gntVld_d = gntVld_q;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_d    = '0;
        gntVld_d = 1'b0;
        if (winAny) begin
          state_d  = ARB_GRANT;
          gnt_d    = winOh;
          gntId_d  = winId;
          gntVld_d = 1'b1;
          ptr_d    = (winId == IDW'(N - 1)) ? '0 : winId + IDW'(1);
        end
      end
      // No preemption: only the holder's own request (or the hold limit) ends a grant.
      ARB_GRANT: begin
        if (!holderReq || holdExpired) begin
          state_d  = ARB_RELEASE;
          gnt_d    = '0;
          gntVld_d = 1'b0;
        end
      end
      ARB_RELEASE: begin
        state_d  = ARB_IDLE;
        gnt_d    = '0;
        gntVld_d = 1'b0;
      end
      default: begin
        state_d  = ARB_IDLE;
        gnt_d    = '0;
        gntVld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gntId_q  <= '0;
      gntVld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gntId_q  <= gntId_d;
      gntVld_q <= gntVld_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gntId_q;
  assign gnt_vld = gntVld_q;

endmodule

// File: tb/tb_vlog_rr_arbiter.sv
// Scoreboard bench for vlog_rr_arbiter (N=4); follows VLOG_RR_ARB_TIMEOUT_EN like the RTL.
module tb_vlog_rr_arbiter;

  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 16;
`ifdef VLOG_RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic           timeout;

  always #5 clock = ~clock;

  vlog_rr_arbiter #(
    .N        (N),
    .IDW      (IDW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  int         totalChecks = 0;
  int         badChecks   = 0;
  logic [7:0] expQ[$];

  // Reference model: 0=idle, 1=grant, 2=release
  int         mState;
  int         mPtr;
  int         mId;
  int         mCnt;
  logic [3:0] mGnt;
  logic       mTo;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0;
    mPtr   = 0;
    mId    = 0;
    mCnt   = 0;
    mGnt   = '0;
    mTo    = 1'b0;
    expQ.delete();
  endtask

  task automatic modelStep(input logic [3:0] r);
    int nState;
    nState = mState;
    mTo    = 1'b0;
    case (mState)
      0: begin
        mGnt = '0;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mPtr + k) % N;
          if (nState == 0 && ((r >> idx) & 4'b0001) != 4'b0000) begin
            mId    = idx;
            mGnt   = 4'(1 << idx);
            mPtr   = (idx + 1) % N;
            mCnt   = 0;
            nState = 1;
          end
        end
      end
      1: begin
        if (((r >> mId) & 4'b0001) == 4'b0000) begin
          mGnt   = '0;
          nState = 2;
        end else if (TO_EN && mCnt == MAX_HOLD - 1) begin
          mGnt   = '0;
          mTo    = 1'b1;
          nState = 2;
        end else begin
          mCnt++;
        end
      end
      default: begin
        mGnt   = '0;
        nState = 0;
      end
    endcase
    mState = nState;
    expQ.push_back({mTo, (mGnt != 4'b0000), 2'(mId), mGnt});
  endtask

  // Drive req for one clock, predict the result, then compare after the edge.
  task automatic applyStimulus(input logic [3:0] r);
    logic [7:0] e;
    req = r;
    modelStep(r);
    @(posedge clock);
    #1;
    e = expQ.pop_front();
    checkOutput("scoreboard", {timeout, gnt_vld, gnt_id, gnt}, e);
    checkOutput("onehot", $onehot0(gnt), 1);
  endtask

  initial begin
    int hi;
    bit done;
    bit toSeen;

    modelReset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_outs", {timeout, gnt_vld, gnt_id, gnt}, 0);
    reset = 1'b1;

    // single requester
    applyStimulus(4'b0100);
    checkOutput("single_gnt", gnt, 4'b0100);
    checkOutput("single_id", gnt_id, 2);
    applyStimulus(4'b0100);
    applyStimulus(4'b0000);
    checkOutput("single_rel", gnt_vld, 0);
    applyStimulus(4'b0000);

    // wrap: ptr is 3 after the grant to 2
    applyStimulus(4'b1001);
    checkOutput("wrap_id3", gnt_id, 3);
    applyStimulus(4'b0001);
    applyStimulus(4'b1001);
    applyStimulus(4'b1001);
    checkOutput("wrap_id0", gnt_id, 0);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);

    // no preemption
    applyStimulus(4'b0010);
    checkOutput("nopre_gnt", gnt, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1011);
      checkOutput("nopre_hold", gnt, 4'b0010);
    end
    applyStimulus(4'b1001);
    applyStimulus(4'b1001);
    applyStimulus(4'b1001);
    checkOutput("nopre_next", gnt_id, 3);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);

    // rotation with all requesters active
    applyStimulus(4'b1111);
    for (int k = 0; k < 5; k++) begin
      checkOutput("rot_order", gnt_id, k % 4);
      applyStimulus(4'b1111);
      applyStimulus(4'b1111);
      applyStimulus(4'b1111 & ~(4'b0001 << (k % 4)));
      applyStimulus(4'b1111);
      if (k < 4) applyStimulus(4'b1111);
    end
    applyStimulus(4'b0000);

    // asynchronous reset in the middle of a grant
    applyStimulus(4'b0010);
    checkOutput("rst_pre_gnt", gnt, 4'b0010);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_async", {gnt_vld, gnt}, 0);
    modelReset();
    @(posedge clock);
    #1;
    checkOutput("rst_hold", {timeout, gnt_vld, gnt_id, gnt}, 0);
    req   = '0;
    reset = 1'b1;
    applyStimulus(4'b1111);
    checkOutput("rst_ptr", gnt, 4'b0001);
    applyStimulus(4'b1110);
    applyStimulus(4'b0000);

    // persistent single request
    hi = 0;
`ifdef VLOG_RR_ARB_TIMEOUT_EN
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      applyStimulus(4'b0001);
      if (gnt[0]) hi++;
      else if (hi > 0) done = 1'b1;
    end
    checkOutput("to_len", hi, MAX_HOLD);
    checkOutput("to_pulse", timeout, 1);
    applyStimulus(4'b0001);
    checkOutput("to_gap", {timeout, gnt}, 0);
    applyStimulus(4'b0001);
    checkOutput("to_regrant", gnt, 4'b0001);
`else
    toSeen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(4'b0001);
      if (gnt[0]) hi++;
      if (timeout) toSeen = 1'b1;
    end
    checkOutput("hold_len", hi, 1000);
    checkOutput("hold_noto", toSeen, 0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
